// File: rtl/pipeline_skid_stage.sv
// Two-entry pipeline stage (main + skid register) whose in_ready depends only on registered state.
// Optional stall statistics are enabled by defining PIPELINE_SKID_STAGE_STATS_EN.
module pipeline_skid_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_done,
    input  logic               in_is_dependent,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_done,
    output logic               out_is_dependent,
    output logic [DATA_W-1:0]  out_result,
    output logic [INSTR_W-1:0] out_instr,
    output logic               fwd_valid,
    output logic [DATA_W-1:0]  fwd_result,
    output logic [COUNT_W-1:0] stall_count
);

    localparam int unsigned PAY_W = 2 + DATA_W + INSTR_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PAY_W-1:0] main_q, main_d;
    logic [PAY_W-1:0] skid_q, skid_d;
    logic [PAY_W-1:0] in_word;
    logic             accept;
    logic             deliver;

    assign in_word  = {in_done, in_is_dependent, in_result, in_instr};
    assign in_ready = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    assign {out_done, out_is_dependent, out_result, out_instr} = main_q;

    assign fwd_valid  = out_valid && out_done && out_is_dependent;
    assign fwd_result = fwd_valid ? out_result : '0;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_word;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_d = in_word;
                    end else if (accept) begin
                        skid_d  = in_word;
                        state_d = FULL;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a delivery can move data.
                    if (deliver) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPELINE_SKID_STAGE_STATS_EN
    localparam logic [COUNT_W-1:0] CNT_INC = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [COUNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_INC;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Self-checking bench for pipeline_skid_stage: directed scenarios plus random traffic
// compared against a queue-based model of a two-deep FIFO with flush.
module tb_pipeline_skid_stage;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned INSTR_W = 16;
`ifdef PIPELINE_SKID_STAGE_STATS_EN
    localparam int unsigned COUNT_W = 4;
`else
    localparam int unsigned COUNT_W = 16;
`endif
    localparam longint MAX_CNT = (longint'(1) << COUNT_W) - 1;

    typedef struct packed {
        logic               done;
        logic               dep;
        logic [DATA_W-1:0]  result;
        logic [INSTR_W-1:0] instr;
    } pay_t;

    logic               clk;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic               in_done;
    logic               in_is_dependent;
    logic [DATA_W-1:0]  in_result;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic               out_done;
    logic               out_is_dependent;
    logic [DATA_W-1:0]  out_result;
    logic [INSTR_W-1:0] out_instr;
    logic               fwd_valid;
    logic [DATA_W-1:0]  fwd_result;
    logic [COUNT_W-1:0] stall_count;

    pipeline_skid_stage #(
        .DATA_W (DATA_W),
        .INSTR_W(INSTR_W),
        .COUNT_W(COUNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_done         (in_done),
        .in_is_dependent (in_is_dependent),
        .in_result       (in_result),
        .in_instr        (in_instr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_done        (out_done),
        .out_is_dependent(out_is_dependent),
        .out_result      (out_result),
        .out_instr       (out_instr),
        .fwd_valid       (fwd_valid),
        .fwd_result      (fwd_result),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    pay_t   q[$];
    logic   cleared  = 1'b1;
    longint stall_m  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic d, input logic dep,
                         input logic [DATA_W-1:0] r, input logic [INSTR_W-1:0] ins);
        in_valid        = v;
        in_done         = d;
        in_is_dependent = dep;
        in_result       = r;
        in_instr        = ins;
    endtask

    // Model view: a queue of at most two words; head is what downstream sees.
    task automatic check_outputs();
        pay_t head;
        logic exp_fwd;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            head = q[0];
            check("out_done", out_done, head.done);
            check("out_dep", out_is_dependent, head.dep);
            check("out_result", out_result, head.result);
            check("out_instr", out_instr, head.instr);
            exp_fwd = head.done && head.dep;
            check("fwd_valid", fwd_valid, exp_fwd);
            check("fwd_result", fwd_result, exp_fwd ? head.result : '0);
        end else begin
            check("fwd_valid_empty", fwd_valid, 1'b0);
            check("fwd_result_empty", fwd_result, '0);
            if (cleared) begin
                check("payload_cleared", {out_done, out_is_dependent, out_result, out_instr}, '0);
            end
        end
        check("stall_count", stall_count, stall_m[COUNT_W-1:0]);
    endtask

    task automatic cycle();
        logic acc, dlv;
        @(negedge clk);
        check_outputs();
        acc = in_valid && (q.size() < 2) && !flush;
        dlv = out_ready && (q.size() > 0) && !flush;
`ifdef PIPELINE_SKID_STAGE_STATS_EN
        if (flush) stall_m = 0;
        else if (q.size() > 0 && !out_ready && stall_m < MAX_CNT) stall_m++;
`endif
        if (flush) begin
            q.delete();
            cleared = 1'b1;
        end else begin
            if (dlv) void'(q.pop_front());
            if (acc) begin
                q.push_back(pay_t'{in_done, in_is_dependent, in_result, in_instr});
                cleared = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, '0);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_stall", stall_count, '0);
        reset = 1'b1;

        // First acceptance on the first edge after reset release, 1-cycle latency.
        drive(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0001);
        out_ready = 1'b1;
        cycle();
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_out_result", out_result, 16'h1234);
        check("lat_in_ready", in_ready, 1'b1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Back-pressure fills both entries, then drains in order.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0A0A);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 16'hBBBB, 16'h0B0B);
        cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("full_in_ready", in_ready, 1'b0);
        check("full_head", out_result, 16'hAAAA);
        cycle();
        check("full_hold", out_result, 16'hAAAA);
        out_ready = 1'b1;
        cycle();
        check("drain_second", out_result, 16'hBBBB);
        cycle();
        check("drain_empty", out_valid, 1'b0);

        // Flush while full discards held words and the concurrent input.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h1111, 16'h0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 16'h2222, 16'h0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 16'hCCCC, 16'h0C0C);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_result_zero", out_result, '0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Forwarding tap.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 16'h00FF, 16'h0F00);
        cycle();
        check("fwd_hit_valid", fwd_valid, 1'b1);
        check("fwd_hit_result", fwd_result, 16'h00FF);
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'h0F0F, 16'h0F01);
        cycle();
        check("fwd_miss_valid", fwd_valid, 1'b0);
        check("fwd_miss_result", fwd_result, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Stall counter: saturation and flush clear (tied to zero when disabled).
        flush = 1'b1;
        cycle();
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h5555, 16'h0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (20) cycle();
`ifdef PIPELINE_SKID_STAGE_STATS_EN
        check("stall_saturated", stall_count, 4'hF);
`else
        check("stall_tied_zero", stall_count, '0);
`endif
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("stall_after_flush", stall_count, '0);

        // Random traffic against the model, including occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  DATA_W'($urandom), INSTR_W'($urandom));
            out_ready = (i < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset between edges while full.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 16'h7777, 16'h0);
        repeat (3) cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("pre_areset_full", in_ready, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_out_valid", out_valid, 1'b0);
        check("areset_in_ready", in_ready, 1'b1);
        check("areset_out_result", out_result, '0);
        check("areset_fwd_valid", fwd_valid, 1'b0);
        check("areset_stall", stall_count, '0);
        q.delete();
        cleared = 1'b1;
        stall_m = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 16'h9999, 16'h0909);
        cycle();
        check("post_reset_accept", out_result, 16'h9999);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_skid_stage.md
PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of result payload.
REQ-002 SHALL have parameter INSTR_W, default 16: width of instruction payload.
REQ-003 SHALL have parameter COUNT_W, default 16: width of stall counter (macro-gated).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1: discard all held entries.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1: upstream handshake.
REQ-008 SHALL have ports in_done 1, in_is_dependent 1, in_result DATA_W, in_instr INSTR_W, all input: upstream payload.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-010 SHALL have ports out_done 1, out_is_dependent 1, out_result DATA_W, out_instr INSTR_W, all output: registered payload.
REQ-011 SHALL have ports fwd_valid output 1, fwd_result output DATA_W: forwarding tap.
REQ-012 SHALL have port stall_count output COUNT_W: downstream stall cycles (macro-gated).

Function
REQ-013 SHALL hold a main register (drives out_*) and a one-entry skid register; states EMPTY, ONE, FULL.
REQ-014 SHALL accept on in_valid && in_ready; SHALL deliver on out_valid && out_ready.
REQ-015 SHALL drive in_ready = (state != FULL), derived from registered state only, with no combinational path from out_ready.
REQ-016 SHALL drive out_valid = (state != EMPTY).
REQ-017 EMPTY: accept -> load main, go ONE; no accept -> stay.
REQ-018 ONE: accept and deliver -> reload main, stay ONE; accept only -> load skid, go FULL; deliver only -> go EMPTY; neither -> stay.
REQ-019 FULL: deliver -> move skid to main, go ONE; no deliver -> stay, all payload held stable.
REQ-020 SHALL give 1-cycle latency: a word accepted in EMPTY appears on out_* the next cycle.
REQ-021 SHALL preserve order and SHALL never drop or duplicate a word absent flush.
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 flush SHALL take priority over every other event: next state EMPTY, out_valid 0, input word of that cycle discarded, payload registers cleared to 0.
REQ-024 SHALL drive fwd_valid = out_valid && out_done && out_is_dependent, and fwd_result = out_result when fwd_valid, else 0.
REQ-025 Payload widths SHALL pass unmodified; no arithmetic on payload.

Reset
REQ-026 While reset is low: state EMPTY, out_valid 0, in_ready 1, all out_* 0, skid 0, fwd_valid 0, fwd_result 0, stall_count 0.
REQ-027 Reset assertion mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.
REQ-028 First acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro PIPELINE_SKID_STAGE_STATS_EN defined: stall_count increments by 1 each cycle with out_valid && !out_ready, saturates at all-ones, and clears on flush.
REQ-030 Macro PIPELINE_SKID_STAGE_STATS_EN undefined: no counter logic; stall_count tied to 0.

Verification
REQ-031 Reset low then high; in_valid=1, in_result=0x1234, out_ready=1 -> next cycle out_valid=1, out_result=0x1234; in_ready stays 1.
REQ-032 out_ready=0; push 0xAAAA then 0xBBBB -> in_ready=0 after second accept; raise out_ready -> out 0xAAAA then 0xBBBB, in order, none lost.
REQ-033 FULL state, flush=1 with in_valid=1 (0xCCCC) -> next cycle out_valid=0, in_ready=1; 0xCCCC never appears.
REQ-034 Push in_done=1, in_is_dependent=1, in_result=0x00FF -> fwd_valid=1, fwd_result=0x00FF; with in_is_dependent=0 -> fwd_valid=0, fwd_result=0.
REQ-035 With PIPELINE_SKID_STAGE_STATS_EN, COUNT_W=4: hold out_valid with out_ready=0 for 20 cycles -> stall_count=15 (saturated); flush -> 0.
REQ-036 Assert reset low between clock edges while FULL -> out_valid=0 and in_ready=1 before the next clock edge.
